// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, MUL/DIV FSM states, small helpers.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Memory-stage result wins over writeback because it is the younger producer.
  function automatic logic [1:0] fwd_sel(input logic       rw_m,
                                         input logic [4:0] rd_m,
                                         input logic       rw_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_MEM;
    else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    else                                             return FWD_RF;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    else                            return v;
  endfunction

endpackage

// File: rtl/muldiv_stall_fsm.sv
// Sequences a fixed-latency MUL/DIV in Execute: stalls the front of the pipe, then
// pulses done for the cycle in which the Execute instruction finally advances.
module muldiv_stall_fsm
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic md_stall_o,
  output logic busy_o,
  output logic done_o
);

  localparam bit         SINGLE = (MULDIV_LAT == 1);
  localparam logic [3:0] LOAD   = 4'(MULDIV_LAT - 1);

  md_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // A single-cycle op completes combinationally in the start cycle and never leaves IDLE,
  // so the following instruction is not mistaken for a second completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !SINGLE) begin
          state_d = BUSY;
          cnt_d   = LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = (state_q == BUSY);
  assign md_stall_o = ((state_q == IDLE) && start_i && !SINGLE) || busy_o;
  assign done_o     = (state_q == DONE) || ((state_q == IDLE) && start_i && SINGLE);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding control for the five-stage pipeline.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        ResultSrcE0,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MulDivStartE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MulDivBusy,
  output logic        MulDivDoneE,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  logic lw_stall;
  logic md_stall;

  assign ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
  assign ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  muldiv_stall_fsm #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_md_fsm (
    .clk       (clk),
    .reset     (reset),
    .start_i   (MulDivStartE),
    .md_stall_o(md_stall),
    .busy_o    (MulDivBusy),
    .done_o    (MulDivDoneE)
  );

  // A held MUL/DIV must not be squashed, so its stall overrides both flush sources.
  assign StallF = lw_stall || md_stall;
  assign StallD = lw_stall || md_stall;
  assign StallE = md_stall;
  assign FlushM = md_stall;
  assign FlushD = PCSrcE && !md_stall;
  assign FlushE = (lw_stall || PCSrcE) && !md_stall;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= sat_inc(stall_cnt_q, StallF);
      flush_cnt_q <= sat_inc(flush_cnt_q, FlushE);
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a latency-4 instance and a latency-1 instance.
module tb_hazard_unit;

  localparam int LAT = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MulDivStartE, md1_start;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy, MulDivDoneE;
  logic [31:0] StallCycles, FlushCount;
  logic [1:0]  fa_1, fb_1;
  logic        sf_1, sd_1, se_1, fd_1, fe_1, fm_1, busy_1, done_1;
  logic [31:0] sc_1, fc_1;

  always #5 clk = ~clk;

  hazard_unit #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MulDivBusy(MulDivBusy), .MulDivDoneE(MulDivDoneE),
    .StallCycles(StallCycles), .FlushCount(FlushCount));

  hazard_unit #(.MULDIV_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivStartE(md1_start),
    .ForwardAE(fa_1), .ForwardBE(fb_1), .StallF(sf_1), .StallD(sd_1),
    .StallE(se_1), .FlushD(fd_1), .FlushE(fe_1), .FlushM(fm_1),
    .MulDivBusy(busy_1), .MulDivDoneE(done_1),
    .StallCycles(sc_1), .FlushCount(fc_1));

  typedef struct {
    logic [1:0]  fa, fb;
    logic        sf, se, fd, fe, fm, busy, done;
    logic [31:0] sc, fc;
    logic        sf1, busy1, done1;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          age = -1;
  logic [31:0] m_sc = 0, m_fc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    exp_t e;
    exp_t o;
    int   a;
    logic lw, md;
    if (PCSrcE && (MulDivStartE || md1_start)) begin
      failures++;
      $display("FAIL illegal_ctl PCSrcE and MulDivStartE both high at %0t", $time);
    end
    a  = (age >= 0) ? age : (MulDivStartE ? 0 : -1);
    md = (a >= 0) && (a <= LAT - 1);
    lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    e.fa    = ref_fwd(Rs1E);
    e.fb    = ref_fwd(Rs2E);
    e.sf    = lw || md;
    e.se    = md;
    e.fm    = md;
    e.fd    = PCSrcE && !md;
    e.fe    = (lw || PCSrcE) && !md;
    e.busy  = (a >= 1) && (a <= LAT - 1);
    e.done  = (a == LAT);
    e.sc    = PERF ? m_sc : 32'd0;
    e.fc    = PERF ? m_fc : 32'd0;
    e.sf1   = lw;
    e.busy1 = 1'b0;
    e.done1 = md1_start;
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    chk("ForwardAE", ForwardAE, o.fa);
    chk("ForwardBE", ForwardBE, o.fb);
    chk("StallF", StallF, o.sf);
    chk("StallD", StallD, o.sf);
    chk("StallE", StallE, o.se);
    chk("FlushD", FlushD, o.fd);
    chk("FlushE", FlushE, o.fe);
    chk("FlushM", FlushM, o.fm);
    chk("MulDivBusy", MulDivBusy, o.busy);
    chk("MulDivDoneE", MulDivDoneE, o.done);
    chk("StallCycles", StallCycles, o.sc);
    chk("FlushCount", FlushCount, o.fc);
    chk("lat1_StallF", sf_1, o.sf1);
    chk("lat1_Busy", busy_1, o.busy1);
    chk("lat1_DoneE", done_1, o.done1);
    @(posedge clk);
    #1;
    if (reset) begin
      age  = -1;
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (o.sf && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (o.fe && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      age = (a < 0 || a == LAT) ? -1 : a + 1;
    end
  endtask

  task automatic clear_in();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MulDivStartE = 0; md1_start = 0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    tick();

    // forwarding: M over W, x0 never forwarded, W-only path
    RegWriteM = 1; RdM = 5; Rs1E = 5; RegWriteW = 1; RdW = 5; Rs2E = 5;
    tick();
    RdM = 0; RegWriteW = 0;
    tick();
    RegWriteW = 1; RdW = 9; Rs1E = 9; Rs2E = 0;
    tick();
    clear_in();

    // load-use stall, then the load has moved on
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    tick();
    clear_in();
    tick();
    ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    tick();
    clear_in();

    PCSrcE = 1;
    tick();
    clear_in();

    for (int i = 0; i < 24; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE0 = 1'($urandom); RegWriteM = 1'($urandom);
      RegWriteW = 1'($urandom); PCSrcE = 1'($urandom);
      tick();
    end
    clear_in();

    // MUL/DIV held through completion; a load-use hazard during it must not flush E
    MulDivStartE = 1;
    for (int i = 0; i < LAT + 1; i++) begin
      ResultSrcE0 = (i == 1); RdE = (i == 1) ? 5'd3 : 5'd0; Rs1D = 5'd3;
      tick();
    end
    clear_in();
    tick();
    tick();

    // latency-1 instance completes in the start cycle only
    md1_start = 1;
    tick();
    md1_start = 0;
    tick();

    // reset two cycles into an operation aborts it without a done pulse
    MulDivStartE = 1;
    tick();
    tick();
    reset = 1; MulDivStartE = 0;
    tick();
    reset = 0;
    for (int i = 0; i < LAT; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
